// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command FIFO and operand-issue FSM in front of the combinational alu
// Results are presented on a valid/ready port; chained commands reuse the last captured result as A.
module alu_issue_ctrl #(
  parameter int DW     = 8,
  parameter int SW     = 4,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [SW-1:0] cmd_sel,
  input  logic          cmd_chain,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [DW-1:0] alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [SW-1:0] res_sel,
  output logic          busy,
  output logic [7:0]    op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESULT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   last_result;

  logic [DW-1:0]   fifo_a     [DEPTH];
  logic [DW-1:0]   fifo_b     [DEPTH];
  logic [SW-1:0]   fifo_sel   [DEPTH];
  logic            fifo_chain [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [AW-1:0]   head;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign cmd_ready = rst_n && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = rptr[AW-1:0];
  assign pop       = !empty && ((state == S_IDLE) ||
                                (state == S_RESULT && res_valid && res_ready));
  assign busy      = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wptr[AW-1:0]]     <= cmd_a;
      fifo_b[wptr[AW-1:0]]     <= cmd_b;
      fifo_sel[wptr[AW-1:0]]   <= cmd_sel;
      fifo_chain[wptr[AW-1:0]] <= cmd_chain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_sel     <= '0;
      last_result <= '0;
      op_count    <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;

      // Operands are loaded only on a pop, so they stay frozen through SETTLE.
      if (pop) begin
        alu_a   <= fifo_chain[head] ? last_result : fifo_a[head];
        alu_b   <= fifo_b[head];
        alu_sel <= fifo_sel[head];
        cnt     <= CW'(SETTLE - 1);
      end

      case (state)
        S_IDLE: begin
          if (pop) state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            res_data    <= alu_out;
            res_sel     <= alu_sel;
            last_result <= alu_out;
            res_valid   <= 1'b1;
            state       <= S_RESULT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= pop ? S_SETTLE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
